// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding word reads,
// a small instruction FIFO and the decoder-facing output register.
//
// state | meaning
// IDLE  | first cycle after reset, nothing issued yet
// REQ   | request word at pc (held off while the FIFO has no free slot)
// WAIT  | one read in flight, waiting for its data
// FLUSH | read in flight belongs to a redirected-away path; drop its data
module fetch_unit #(
  parameter int          XLEN         = 32,
  parameter int          IF_LEN       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BUF_DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              i_busy,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_addr,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [IF_LEN-1:0] mem_rdata,
  output logic [IF_LEN-1:0] instruction,
  output logic [XLEN-1:0]   o_address,
  output logic              o_valid,
  output logic              misaligned
);

  localparam int              AW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(BUF_DEPTH);
  localparam logic [IF_LEN-1:0] NOP    = IF_LEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] RV       = XLEN'(RESET_VECTOR);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

  state_t            state, state_nx;
  logic [XLEN-1:0]   pc, pc_nx;

  logic [IF_LEN-1:0] buf_data [BUF_DEPTH];
  logic [XLEN-1:0]   buf_addr [BUF_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [AW:0]       count, count_nx;

  logic              push_in;
  logic              pop_head;
  logic              bypass;
  logic              fifo_wr;
  logic [XLEN-1:0]   push_addr;

  // The in-flight word's address is pc-4: pc advanced when the request was
  // accepted and cannot move again until the data returns or a redirect.
  assign push_addr = pc - XLEN'(4);
  assign push_in   = (state == WAIT) && mem_rvalid && !redirect;
  assign pop_head  = !i_busy && (count != '0);
  // With an empty FIFO the returning word goes straight to the output so
  // a zero-wait memory sees no extra buffering cycle.
  assign bypass    = !i_busy && (count == '0) && push_in;
  assign fifo_wr   = push_in && !bypass;
  assign count_nx  = count + (AW+1)'(fifo_wr) - (AW+1)'(pop_head);

  assign mem_req   = (state == REQ) && (count != CNT_FULL);
  assign mem_addr  = pc;

  // Next state and next pc; a redirect overrides sequential fetch.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    case (state)
      IDLE:  state_nx = REQ;
      REQ: begin
        if (mem_req && mem_ack) begin
          state_nx = WAIT;
          pc_nx    = pc + XLEN'(4);
        end
      end
      WAIT:  if (mem_rvalid) state_nx = REQ;
      FLUSH: if (mem_rvalid) state_nx = REQ;
      default: state_nx = IDLE;
    endcase
    if (redirect) begin
      pc_nx = redirect_addr & ~XLEN'(3);
      case (state)
        REQ:     state_nx = (mem_req && mem_ack) ? FLUSH : REQ;
        WAIT,
        FLUSH:   state_nx = mem_rvalid ? REQ : FLUSH;
        default: state_nx = REQ;
      endcase
    end
  end

  // State and pc registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RV;
    end else if (clk_en) begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  // FIFO storage; contents only matter below count, so no reset.
  always_ff @(posedge clk) begin
    if (clk_en && fifo_wr) begin
      buf_data[wr_ptr] <= mem_rdata;
      buf_addr[wr_ptr] <= push_addr;
    end
  end

  // FIFO pointers, output register and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      o_valid     <= 1'b0;
      instruction <= NOP;
      o_address   <= '0;
      misaligned  <= 1'b0;
    end else if (clk_en) begin
      if (redirect) begin
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
        o_valid     <= 1'b0;
        instruction <= NOP;
        misaligned  <= |redirect_addr[1:0];
      end else begin
        if (fifo_wr)  wr_ptr <= wr_ptr + AW'(1);
        if (pop_head) rd_ptr <= rd_ptr + AW'(1);
        count <= count_nx;
        if (!i_busy) begin
          if (count != '0) begin
            instruction <= buf_data[rd_ptr];
            o_address   <= buf_addr[rd_ptr];
            o_valid     <= 1'b1;
          end else if (push_in) begin
            instruction <= mem_rdata;
            o_address   <= push_addr;
            o_valid     <= 1'b1;
          end else begin
            instruction <= NOP;
            o_valid     <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model returning each word's own address as
// data, and a program-order reference (next expected PC) for every word the
// decoder accepts.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, clk_en, i_busy, redirect;
  logic [31:0] redirect_addr;
  logic        mem_req, mem_ack, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic [31:0] instruction, o_address;
  logic        o_valid, misaligned;

  fetch_unit #(.XLEN(32), .IF_LEN(32), .RESET_VECTOR(RV), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_busy(i_busy),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instruction(instruction), .o_address(o_address),
    .o_valid(o_valid), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // stimulus knobs
  logic        rst_v = 1'b1, en_v = 1'b1, busy_v = 1'b0, redir_v = 1'b0;
  logic [31:0] raddr_v = '0;
  int          ack_pct = 100, lat_min = 0, lat_max = 0;

  // memory model
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  int          lat = 0;
  int          n_acc = 0;
  logic        dut_pend = 1'b0;

  // reference: next PC the decoder must receive, expected sticky flag
  logic [31:0] exp_addr = RV;
  logic        exp_mis = 1'b0;
  int          n_cons = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_req"},  {31'b0, mem_req},    32'h0);
    chk({tag, "_mem_addr"}, mem_addr,             RV);
    chk({tag, "_o_valid"},  {31'b0, o_valid},    32'h0);
    chk({tag, "_instr"},    instruction,          32'h0000_0013);
    chk({tag, "_o_addr"},   o_address,            32'h0);
    chk({tag, "_misalign"}, {31'b0, misaligned}, 32'h0);
  endtask

  // One clock: drive inputs at negedge, check and update models, leave
  // the posedge to the caller's next wait.
  task automatic tick();
    @(negedge clk);
    rst           = rst_v;
    clk_en        = en_v;
    i_busy        = busy_v;
    redirect      = redir_v;
    redirect_addr = raddr_v;
    mem_ack       = en_v && !rst_v && !pend && ($urandom_range(0, 99) < ack_pct);
    mem_rvalid    = en_v && pend && (lat == 0);
    mem_rdata     = mem_rvalid ? paddr : $urandom;
    #1;
    if (!rst_v) begin
      chk("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
      chk("mem_addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
      chk("one_outstanding", {31'b0, mem_req && dut_pend}, 32'h0);
    end
    if (rst_v) begin
      exp_addr = RV;
      exp_mis  = 1'b0;
      dut_pend = 1'b0;
    end else if (en_v) begin
      if (redir_v) begin
        exp_addr = raddr_v & ~32'h3;
        exp_mis  = |raddr_v[1:0];
      end else if (o_valid && !busy_v) begin
        chk("o_address", o_address, exp_addr);
        chk("instruction", instruction, exp_addr);
        exp_addr = exp_addr + 32'd4;
        n_cons++;
      end
    end
    if (en_v) begin
      if (mem_req && mem_ack) begin
        pend     = 1'b1;
        paddr    = mem_addr;
        lat      = $urandom_range(lat_min, lat_max);
        n_acc++;
        dut_pend = 1'b1;
      end else if (mem_rvalid) begin
        pend     = 1'b0;
        dut_pend = 1'b0;
      end else if (pend && lat > 0) begin
        lat--;
      end
    end
    redir_v = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] a);
    en_v    = 1'b1;
    redir_v = 1'b1;
    raddr_v = a;
    tick();
  endtask

  task automatic wait_pend(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = pend;
    end
    chk(tag, {31'b0, found}, 32'h1);
  endtask

  initial begin
    logic [31:0] held;
    int a0, c0;

    // reset
    repeat (3) tick();
    @(posedge clk); #1;
    chk_reset("init");

    // zero-wait latency: valid three cycles after reset, then every two
    rst_v = 1'b0;
    repeat (3) tick();
    chk("lat_early", {31'b0, o_valid}, 32'h0);
    @(posedge clk); #1;
    chk("lat_first_valid", {31'b0, o_valid}, 32'h1);
    chk("lat_first_addr", o_address, 32'h0);
    chk("lat_first_instr", instruction, 32'h0);
    tick();
    tick();
    chk("lat_gap", {31'b0, o_valid}, 32'h0);
    @(posedge clk); #1;
    chk("lat_second_valid", {31'b0, o_valid}, 32'h1);
    chk("lat_second_addr", o_address, 32'h4);

    // decoder back-pressure
    held   = o_address;
    busy_v = 1'b1;
    a0     = n_acc;
    repeat (10) begin
      tick();
      chk("busy_hold_addr", o_address, held);
      chk("busy_hold_valid", {31'b0, o_valid}, 32'h1);
    end
    chk("busy_req_dropped", {31'b0, mem_req}, 32'h0);
    chk("busy_fetch_bound", {31'b0, (n_acc - a0) <= 2}, 32'h1);
    busy_v = 1'b0;
    c0 = n_cons;
    repeat (12) tick();
    chk("busy_resume", {31'b0, (n_cons - c0) >= 3}, 32'h1);

    // redirect while waiting on a slow read, FIFO partly filled
    lat_min = 3; lat_max = 3;
    busy_v  = 1'b1;
    wait_pend("timeout_pend_redirect");
    do_redirect(32'h0000_0100);
    busy_v  = 1'b0;
    lat_min = 0; lat_max = 0;
    c0 = n_cons;
    repeat (20) tick();
    chk("redirect_progress", {31'b0, (n_cons - c0) >= 3}, 32'h1);

    // misaligned target and its clearing
    do_redirect(32'h0000_0102);
    @(posedge clk); #1;
    chk("mis_set", {31'b0, misaligned}, 32'h1);
    chk("mis_mem_addr", mem_addr, 32'h0000_0100);
    repeat (10) tick();
    do_redirect(32'h0000_0200);
    @(posedge clk); #1;
    chk("mis_clear", {31'b0, misaligned}, 32'h0);
    repeat (10) tick();

    // PC wrap at the top of the address space
    do_redirect(32'hFFFF_FFF8);
    c0 = n_cons;
    repeat (16) tick();
    chk("wrap_progress", {31'b0, (n_cons - c0) >= 3}, 32'h1);

    // reset with clock enable low while a read is in flight
    lat_min = 3; lat_max = 3;
    wait_pend("timeout_pend_reset");
    rst_v = 1'b1;
    en_v  = 1'b0;
    tick();
    @(posedge clk); #1;
    chk_reset("rst_wait");
    rst_v   = 1'b0;
    en_v    = 1'b1;
    lat_min = 0; lat_max = 0;
    c0 = n_cons;
    repeat (24) tick();
    chk("rst_restart", {31'b0, (n_cons - c0) >= 3}, 32'h1);

    // randomized traffic
    ack_pct = 60; lat_min = 0; lat_max = 3;
    c0 = n_cons;
    for (int i = 0; i < 3000; i++) begin
      busy_v = ($urandom_range(0, 3) == 0);
      en_v   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        en_v    = 1'b1;
        redir_v = 1'b1;
        raddr_v = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : ($urandom & 32'h0000_3FFF);
      end
      tick();
    end
    chk("random_progress", {31'b0, (n_cons - c0) > 100}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
